add_arb_seq: RTL
================

ADD_ARB_SEQ -- requirements
Module: add_arb_seq

Interface
REQ-001 Clock  input  1  system clock, all state updates on rising edge.
REQ-002 Resetn  input  1  reset, asynchronous, active-low.
REQ-003 req  input  2  operation requests; bit i belongs to requester i; held high until that requester's gnt bit pulses.
REQ-004 x0, y0  input  16  requester-0 operands.
REQ-005 x1, y1  input  16  requester-1 operands.
REQ-006 sub  input  2  per-requester subtract select, sampled with operands (only with SUB_EN).
REQ-007 gnt  output  2  one-hot, one-cycle pulse marking the accepted requester.
REQ-008 busy  output  1  high from the cycle after grant through the DONE cycle.
REQ-009 done  output  1  one-cycle pulse, result valid.
REQ-010 owner  output  1  requester index of the current/last result.
REQ-011 S  output  17  result: carry/borrow-out in bit 16, sum in bits 15:0.

Function
REQ-012 SHALL contain exactly one 4-bit adder (4-bit X, 4-bit Y, carry-in, 5-bit sum); 16-bit results are produced by sequencing it over nibbles.
REQ-013 FSM states SHALL be IDLE, ADD, DONE.
REQ-014 IDLE: when any req bit is high, grant one requester, latch its x, y (and sub), pulse gnt, clear the nibble counter, clear the carry register, and go to ADD on the next edge.
REQ-015 Arbitration SHALL be round-robin: a single requester is granted directly; when both request, grant the one not granted last.
REQ-016 ADD: each cycle SHALL add nibble k (k = 0..3, LSB first) with carry-in from the carry register, write S[4k+3:4k], and store the carry-out.
REQ-017 After nibble 3, S[16] SHALL take the final carry and the FSM SHALL go to DONE; the add occupies exactly 4 ADD cycles.
REQ-018 DONE: pulse done for one cycle, then return to IDLE; the earliest next gnt is the cycle after DONE.
REQ-019 Latency SHALL be 6 cycles from the gnt cycle to the done cycle inclusive.
REQ-020 S and owner SHALL hold their values until the next grant changes them.
REQ-021 req is ignored outside IDLE; operand changes after grant SHALL NOT affect the result.
REQ-022 Arithmetic SHALL be modulo 2^16 with carry in S[16]; 0xFFFF+0x0001 SHALL give S = 0x1_0000.
REQ-023 A request arriving in DONE SHALL be granted in the following IDLE cycle, not dropped.

Reset
REQ-024 Resetn low SHALL immediately force state IDLE, gnt=0, busy=0, done=0, owner=0, S=0, carry=0, nibble counter=0, with requester 0 preferred on the first tie.
REQ-025 Reset during ADD or DONE SHALL abort the operation without a done pulse; after release the block behaves as freshly reset.

Configuration
REQ-026 Macro ADD_ARB_SEQ_SUB_EN: when defined, a latched sub=1 SHALL invert Y per nibble and set the initial carry to 1, giving X-Y with S[16]=1 meaning no borrow.
REQ-027 Without ADD_ARB_SEQ_SUB_EN, the sub port SHALL be absent and every operation SHALL be an add.

Verification
REQ-028 Single add: req=01, x0=0x1234, y0=0x4321 -> gnt=01, done 6 cycles after gnt inclusive, S=0x0_5555, owner=0.
REQ-029 Carry chain: x1=0xFFFF, y1=0x0001 on requester 1 -> S=0x1_0000, owner=1.
REQ-030 Tie fairness: req=11 held continuously after reset -> grants alternate 01, 10, 01, 10, with each gnt the cycle after the previous done.
REQ-031 Mid-operation: change x0 and raise req1 during ADD -> result uses the latched operands; requester 1 is granted after DONE.
REQ-032 Reset abort: drop Resetn during the 2nd ADD cycle -> all outputs 0 immediately, no done pulse; a new request completes normally.
REQ-033 With ADD_ARB_SEQ_SUB_EN: x0=0x0005, y0=0x0007, sub=01 -> S=0x0_FFFE (borrow); x0=7, y0=5 -> S=0x1_0002.

Source files
------------

// File: rtl/add_arb_seq_if.sv
// add_arb_seq_if -- request/operand/result bundle for add_arb_seq.
//
// Requester side (master) drives:
//   req[1:0]          request per requester, held until its gnt bit pulses
//   x0, y0, x1, y1    16-bit operands for requester 0 and requester 1
//   sub[1:0]          per-requester subtract select (only with ADD_ARB_SEQ_SUB_EN)
// Arbiter/adder side (slave) drives:
//   gnt[1:0]          one-hot, one-cycle grant pulse
//   busy              high from the cycle after grant through the DONE cycle
//   done              one-cycle result-valid pulse
//   owner             requester index of the current/last result
//   S[16:0]           carry/borrow-out in bit 16, sum in bits 15:0
//
// Optional feature macro: ADD_ARB_SEQ_SUB_EN (adds the sub signal).
interface add_arb_seq_if;
    logic [1:0]  req;
    logic [15:0] x0;
    logic [15:0] y0;
    logic [15:0] x1;
    logic [15:0] y1;
`ifdef ADD_ARB_SEQ_SUB_EN
    logic [1:0]  sub;
`endif
    logic [1:0]  gnt;
    logic        busy;
    logic        done;
    logic        owner;
    logic [16:0] S;

`ifdef ADD_ARB_SEQ_SUB_EN
    modport master (output req, x0, y0, x1, y1, sub,
                    input  gnt, busy, done, owner, S);
    modport slave  (input  req, x0, y0, x1, y1, sub,
                    output gnt, busy, done, owner, S);
`else
    modport master (output req, x0, y0, x1, y1,
                    input  gnt, busy, done, owner, S);
    modport slave  (input  req, x0, y0, x1, y1,
                    output gnt, busy, done, owner, S);
`endif
endinterface

// File: rtl/add_arb_seq.sv
// add_arb_seq -- two-requester round-robin arbiter in front of a 16-bit
// adder built from a single 4-bit adder stepped over four nibbles.
//
// Ports:
//   clk    system clock, rising-edge
//   rst_n  asynchronous active-low reset
//   bus    add_arb_seq_if.slave (req/operands in, gnt/busy/done/owner/S out)
//
// Timeline of one operation (cycle c = gnt cycle):
//   c        gnt pulse, state still IDLE, operands already latched
//   c+1..c+4 ADD, one nibble per cycle, LSB first
//   c+5      DONE, done pulse
// A grant can be issued on the edge leaving DONE, so back-to-back requests
// see their gnt in the cycle right after done.
//
// Optional feature macro: ADD_ARB_SEQ_SUB_EN -- when defined, a latched
// sub=1 inverts Y per nibble and starts with carry 1 (X-Y, S[16]=1 = no borrow).
module add_arb_seq (
    input  logic         clk,
    input  logic         rst_n,
    add_arb_seq_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        owner_q, owner_d;
    logic [16:0] s_q, s_d;
    logic        carry_q, carry_d;
    logic [1:0]  nib_q, nib_d;
    logic        last_q, last_d;
    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;
`ifdef ADD_ARB_SEQ_SUB_EN
    logic        sub_q, sub_d;
`endif

    logic        grant_ok;
    logic        sel;
    logic [3:0]  base;
    logic [3:0]  nib_x;
    logic [3:0]  nib_y;
    logic [4:0]  nib_sum;

    // Next-state logic: the single 4-bit adder, the FSM and the arbiter.
    always_comb begin
        state_d = state_q;
        gnt_d   = 2'b00;
        busy_d  = busy_q;
        done_d  = 1'b0;
        owner_d = owner_q;
        s_d     = s_q;
        carry_d = carry_q;
        nib_d   = nib_q;
        last_d  = last_q;
        x_d     = x_q;
        y_d     = y_q;
`ifdef ADD_ARB_SEQ_SUB_EN
        sub_d   = sub_q;
`endif

        // The only adder in the design: one nibble of the latched operands.
        base  = {nib_q, 2'b00};
        nib_x = x_q[base +: 4];
`ifdef ADD_ARB_SEQ_SUB_EN
        nib_y = sub_q ? ~y_q[base +: 4] : y_q[base +: 4];
`else
        nib_y = y_q[base +: 4];
`endif
        nib_sum = {1'b0, nib_x} + {1'b0, nib_y} + {4'b0000, carry_q};

        case (state_q)
            IDLE: begin
                // A pending gnt pulse means operands are latched: start adding.
                if (gnt_q != 2'b00) begin
                    state_d = ADD;
                    busy_d  = 1'b1;
                end
            end
            ADD: begin
                s_d[base +: 4] = nib_sum[3:0];
                carry_d        = nib_sum[4];
                nib_d          = nib_q + 2'd1;
                if (nib_q == 2'd3) begin
                    s_d[16] = nib_sum[4];
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Grants are issued from idle (when none is pending) or on the edge
        // leaving DONE, so a request seen during DONE is not lost.
        grant_ok = (state_q == DONE) || ((state_q == IDLE) && (gnt_q == 2'b00));
        // Round-robin: on a tie pick the requester not granted last.
        sel = (bus.req == 2'b11) ? ~last_q : bus.req[1];

        if (grant_ok && (bus.req != 2'b00)) begin
            gnt_d   = sel ? 2'b10 : 2'b01;
            last_d  = sel;
            owner_d = sel;
            x_d     = sel ? bus.x1 : bus.x0;
            y_d     = sel ? bus.y1 : bus.y0;
            nib_d   = 2'd0;
`ifdef ADD_ARB_SEQ_SUB_EN
            sub_d   = bus.sub[sel];
            carry_d = bus.sub[sel];
`else
            carry_d = 1'b0;
`endif
        end
    end

    // State register. last_q resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            owner_q <= 1'b0;
            s_q     <= 17'd0;
            carry_q <= 1'b0;
            nib_q   <= 2'd0;
            last_q  <= 1'b1;
            x_q     <= 16'd0;
            y_q     <= 16'd0;
`ifdef ADD_ARB_SEQ_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            owner_q <= owner_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            nib_q   <= nib_d;
            last_q  <= last_d;
            x_q     <= x_d;
            y_q     <= y_d;
`ifdef ADD_ARB_SEQ_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.owner = owner_q;
    assign bus.S     = s_q;

endmodule
